// File: rtl/truth_pkg.sv
// ---------------------------------------------------------------------------
// truth_pkg
// Shared definitions for the truth-table capture block:
//   state_t    - capture FSM states (IDLE, CAPTURE, DONE, ERROR)
//   GATE_*     - 3-bit gate classification codes reported on gate_code
//   TT_*       - captured truth tables (bit index {A,B}) for each gate
// ---------------------------------------------------------------------------
package truth_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2,
      ERROR   = 2'd3
   } state_t;

   localparam logic [2:0] GATE_NONE = 3'd0;
   localparam logic [2:0] GATE_AND  = 3'd1;
   localparam logic [2:0] GATE_OR   = 3'd2;
   localparam logic [2:0] GATE_XOR  = 3'd3;
   localparam logic [2:0] GATE_NAND = 3'd4;
   localparam logic [2:0] GATE_NOR  = 3'd5;
   localparam logic [2:0] GATE_XNOR = 3'd6;

   localparam logic [3:0] TT_AND  = 4'h8;
   localparam logic [3:0] TT_OR   = 4'hE;
   localparam logic [3:0] TT_XOR  = 4'h6;
   localparam logic [3:0] TT_NAND = 4'h7;
   localparam logic [3:0] TT_NOR  = 4'h1;
   localparam logic [3:0] TT_XNOR = 4'h9;

endpackage

// File: rtl/gate_classifier.sv
// ---------------------------------------------------------------------------
// gate_classifier
// Decodes a completed truth table into a gate code. Only built when the
// GATE_CLASSIFY_EN macro is defined; otherwise this file contributes nothing.
// Ports:
//   table_q   in  [3:0] captured truth table, bit {A,B} = Y
//   done      in        capture complete; code is forced to GATE_NONE if 0
//   gate_code out [2:0] GATE_* classification
// ---------------------------------------------------------------------------
`ifdef GATE_CLASSIFY_EN
module gate_classifier
   import truth_pkg::*;
(
   input  logic [3:0] table_q,
   input  logic       done,
   output logic [2:0] gate_code
);

   always_comb begin
      gate_code = GATE_NONE;
      if (done) begin
         case (table_q)
            TT_AND:  gate_code = GATE_AND;
            TT_OR:   gate_code = GATE_OR;
            TT_XOR:  gate_code = GATE_XOR;
            TT_NAND: gate_code = GATE_NAND;
            TT_NOR:  gate_code = GATE_NOR;
            TT_XNOR: gate_code = GATE_XNOR;
            default: gate_code = GATE_NONE;
         endcase
      end
   end

endmodule
`endif

// File: rtl/truth_table_capture.sv
// ---------------------------------------------------------------------------
// truth_table_capture
// Captures the truth table of an unknown 2-input gate from a stream of
// {A,B,Y} observations, flags contradictory observations and idle timeouts,
// and (optionally) classifies the completed table.
// Optional feature: define GATE_CLASSIFY_EN to build the gate_classifier
// decoder; without it gate_code is tied to 3'b000.
// Parameters:
//   TIMEOUT   max idle cycles in CAPTURE before error (1..65535)
// Ports:
//   clk        in        clock, rising edge
//   rst_n      in        asynchronous active-low reset
//   start      in        clear and (re)start capture, any state
//   in_valid   in        observation {A,B,Y} presented
//   in_ready   out       observation can be accepted (CAPTURE only)
//   A, B, Y    in        operand pair and gate result
//   table_q    out [3:0] captured Y per row, bit {A,B}
//   seen       out [3:0] row {A,B} has been captured
//   done       out       all four rows captured
//   conflict   out       a row was observed with two different Y values
//   timeout    out       TIMEOUT idle cycles elapsed in CAPTURE
//   gate_code  out [2:0] classified gate (GATE_* codes)
// ---------------------------------------------------------------------------
module truth_table_capture
   import truth_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       A,
   input  logic       B,
   input  logic       Y,
   output logic [3:0] table_q,
   output logic [3:0] seen,
   output logic       done,
   output logic       conflict,
   output logic       timeout,
   output logic [2:0] gate_code
);

   localparam int unsigned   CW  = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   state_t          r_state;
   logic [3:0]      r_table;
   logic [3:0]      r_seen;
   logic            r_done;
   logic            r_conflict;
   logic            r_timeout;
   logic [CW-1:0]   r_cnt;

   state_t          w_state_nxt;
   logic [3:0]      w_table_nxt;
   logic [3:0]      w_seen_nxt;
   logic            w_done_nxt;
   logic            w_conflict_nxt;
   logic            w_timeout_nxt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [1:0]      w_idx;
   logic [3:0]      w_seen_upd;
   logic [2:0]      w_gate_code;

   assign w_idx      = {A, B};
   assign w_seen_upd = r_seen | (4'b0001 << w_idx);

   // State register and all datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_table    <= '0;
         r_seen     <= '0;
         r_done     <= 1'b0;
         r_conflict <= 1'b0;
         r_timeout  <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_table    <= w_table_nxt;
         r_seen     <= w_seen_nxt;
         r_done     <= w_done_nxt;
         r_conflict <= w_conflict_nxt;
         r_timeout  <= w_timeout_nxt;
         r_cnt      <= w_cnt_nxt;
      end
   end

   // Next-state and datapath update. start has top priority so a sample
   // presented alongside it is dropped.
   always_comb begin
      w_state_nxt    = r_state;
      w_table_nxt    = r_table;
      w_seen_nxt     = r_seen;
      w_done_nxt     = r_done;
      w_conflict_nxt = r_conflict;
      w_timeout_nxt  = r_timeout;
      w_cnt_nxt      = r_cnt;

      if (start) begin
         w_state_nxt    = CAPTURE;
         w_table_nxt    = '0;
         w_seen_nxt     = '0;
         w_done_nxt     = 1'b0;
         w_conflict_nxt = 1'b0;
         w_timeout_nxt  = 1'b0;
         w_cnt_nxt      = '0;
      end else if (r_state == CAPTURE) begin
         if (in_valid) begin
            w_cnt_nxt = '0;
            if (!r_seen[w_idx]) begin
               w_table_nxt[w_idx] = Y;
               w_seen_nxt[w_idx]  = 1'b1;
               if (w_seen_upd == 4'b1111) begin
                  w_state_nxt = DONE;
                  w_done_nxt  = 1'b1;
               end
            end else if (r_table[w_idx] != Y) begin
               w_conflict_nxt = 1'b1;
               w_state_nxt    = ERROR;
            end
         end else begin
            // Saturating idle count; the edge on which it reaches TIMEOUT
            // raises timeout.
            if (r_cnt != TMO) begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
            if (r_cnt == TMO - CW'(1)) begin
               w_timeout_nxt = 1'b1;
               w_state_nxt   = ERROR;
            end
         end
      end
   end

`ifdef GATE_CLASSIFY_EN
   gate_classifier u_gate_classifier (
      .table_q   (r_table),
      .done      (r_done),
      .gate_code (w_gate_code)
   );
`else
   assign w_gate_code = GATE_NONE;
`endif

   assign in_ready  = (r_state == CAPTURE);
   assign table_q   = r_table;
   assign seen      = r_seen;
   assign done      = r_done;
   assign conflict  = r_conflict;
   assign timeout   = r_timeout;
   assign gate_code = w_gate_code;

endmodule

// File: tb/tb_truth_table_capture.sv
// ---------------------------------------------------------------------------
// tb_truth_table_capture
// Self-checking bench for truth_table_capture (TIMEOUT overridden to 4).
// A behavioural reference model tracks the expected outputs; directed
// scenarios plus a randomized stream are compared against it each cycle.
// ---------------------------------------------------------------------------
module tb_truth_table_capture;

   localparam int TMO = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       in_valid;
   logic       A, B, Y;
   logic       in_ready;
   logic [3:0] table_q;
   logic [3:0] seen;
   logic       done;
   logic       conflict;
   logic       timeout;
   logic [2:0] gate_code;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: phase 0 idle, 1 capturing, 2 complete, 3 error
   int       m_phase;
   bit [3:0] m_tab;
   bit [3:0] m_seen;
   bit       m_done, m_conf, m_to;
   int       m_idle;

   truth_table_capture #(.TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Y         (Y),
      .table_q   (table_q),
      .seen      (seen),
      .done      (done),
      .conflict  (conflict),
      .timeout   (timeout),
      .gate_code (gate_code)
   );

   always #5 clk = ~clk;

   wire [14:0] dut_vec = {table_q, seen, done, conflict, timeout, in_ready, gate_code};

   // Expected gate code: try each gate's boolean function on all four rows
   function automatic logic [2:0] ref_gate(input bit [3:0] t, input bit d);
      bit [3:0] tt;
      int       res;
      ref_gate = 3'd0;
`ifdef GATE_CLASSIFY_EN
      if (d) begin
         for (int g = 1; g <= 6; g++) begin
            for (int a = 0; a < 2; a++) begin
               for (int b = 0; b < 2; b++) begin
                  case (g)
                     1:       res = a & b;
                     2:       res = a | b;
                     3:       res = a ^ b;
                     4:       res = 1 - (a & b);
                     5:       res = 1 - (a | b);
                     default: res = 1 - (a ^ b);
                  endcase
                  tt[a*2+b] = (res != 0);
               end
            end
            if (tt == t) ref_gate = g[2:0];
         end
      end
`else
      tt  = t;
      res = int'(d);
`endif
   endfunction

   function automatic logic [14:0] exp_vec();
      return {m_tab, m_seen, m_done, m_conf, m_to, (m_phase == 1), ref_gate(m_tab, m_done)};
   endfunction

   task automatic model_reset();
      m_phase = 0; m_tab = '0; m_seen = '0;
      m_done = 0; m_conf = 0; m_to = 0; m_idle = 0;
   endtask

   // Advance the model by one clock using the currently driven inputs
   task automatic model_step();
      int idx;
      if (start) begin
         m_phase = 1; m_tab = '0; m_seen = '0;
         m_done = 0; m_conf = 0; m_to = 0; m_idle = 0;
      end else if (m_phase == 1) begin
         if (in_valid) begin
            idx = int'(A) * 2 + int'(B);
            m_idle = 0;
            if (!m_seen[idx]) begin
               m_tab[idx]  = Y;
               m_seen[idx] = 1'b1;
               if (m_seen == 4'hF) begin m_done = 1; m_phase = 2; end
            end else if (m_tab[idx] != Y) begin
               m_conf = 1; m_phase = 3;
            end
         end else begin
            m_idle++;
            if (m_idle >= TMO) begin m_to = 1; m_phase = 3; end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic v, input logic a, input logic b, input logic y);
      start = s; in_valid = v; A = a; B = b; Y = y;
   endtask

   task automatic do_start();
      drive(1, 0, 0, 0, 0);
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0);
      #12;
      model_reset();
      n_checks++;
      if (dut_vec !== 15'h0) begin
         $display("FAIL reset_outputs: got %h expected %h", dut_vec, 15'h0); n_fail++;
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(0, 1, 1, 0, 1);
      tick(); tick();
      n_checks++;
      if (in_ready !== 1'b0 || dut_vec !== exp_vec()) begin
         $display("FAIL idle_after_reset: got %h expected %h", dut_vec, exp_vec()); n_fail++;
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_gc;
`ifdef GATE_CLASSIFY_EN
      exp_gc = 3'd3;
`else
      exp_gc = 3'd0;
`endif
      do_start();
      n_checks++;
      if (in_ready !== 1'b1) begin
         $display("FAIL b2b_ready: got %b expected 1", in_ready); n_fail++;
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, i[1], i[0], (i == 1 || i == 2));
         tick();
         n_checks++;
         if (done !== (i == 3)) begin
            $display("FAIL b2b_done_row%0d: got %b expected %b", i, done, (i == 3)); n_fail++;
         end
      end
      n_checks++;
      if (table_q !== 4'b0110 || gate_code !== exp_gc || dut_vec !== exp_vec()) begin
         $display("FAIL b2b_result: got table %b gate %0d expected table 0110 gate %0d", table_q, gate_code, exp_gc); n_fail++;
      end
      drive(0, 1, 1, 1, 1);
      tick(); tick();
      n_checks++;
      if (table_q !== 4'b0110 || done !== 1'b1 || dut_vec !== exp_vec()) begin
         $display("FAIL done_hold: got %h expected %h", dut_vec, exp_vec()); n_fail++;
      end
   endtask

   task automatic test_conflict();
      do_start();
      drive(0, 1, 1, 1, 1); tick();
      drive(0, 1, 1, 1, 0); tick();
      n_checks++;
      if (conflict !== 1'b1 || in_ready !== 1'b0 || table_q[3] !== 1'b1 || dut_vec !== exp_vec()) begin
         $display("FAIL conflict: got %h expected %h", dut_vec, exp_vec()); n_fail++;
      end
      drive(0, 1, 0, 0, 1); tick(); tick();
      n_checks++;
      if (seen !== 4'b1000 || dut_vec !== exp_vec()) begin
         $display("FAIL error_hold: got %h expected %h", dut_vec, exp_vec()); n_fail++;
      end
   endtask

   task automatic test_timeout();
      do_start();
      drive(0, 0, 0, 0, 0);
      for (int k = 1; k <= 5; k++) begin
         tick();
         n_checks++;
         if (timeout !== (k >= 4) || dut_vec !== exp_vec()) begin
            $display("FAIL timeout_cycle%0d: got timeout %b expected %b", k, timeout, (k >= 4)); n_fail++;
         end
      end
   endtask

   task automatic test_start_priority();
      do_start();
      drive(1, 1, 1, 0, 1);
      tick();
      start = 1'b0; in_valid = 1'b0;
      n_checks++;
      if (seen !== 4'b0000 || table_q !== 4'b0000 || in_ready !== 1'b1) begin
         $display("FAIL start_priority: got seen %b table %b ready %b expected 0000 0000 1", seen, table_q, in_ready); n_fail++;
      end
   endtask

   task automatic test_duplicate();
      bit [3:0] ys;
      ys = 4'($urandom);
      do_start();
      drive(0, 1, 0, 0, 1); tick();
      drive(0, 1, 0, 0, 1); tick();
      for (int i = 1; i < 4; i++) begin
         drive(0, 1, i[1], i[0], ys[i]); tick();
      end
      n_checks++;
      if (conflict !== 1'b0 || done !== 1'b1 || table_q[0] !== 1'b1 || dut_vec !== exp_vec()) begin
         $display("FAIL duplicate: got %h expected %h", dut_vec, exp_vec()); n_fail++;
      end
   endtask

   task automatic test_all_gates();
      bit [3:0] tv;
      int       ord [4];
      int       j, tmp;
      for (int t = 0; t < 16; t++) begin
         tv = t[3:0];
         for (int i = 0; i < 4; i++) ord[i] = i;
         for (int i = 3; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
         end
         do_start();
         for (int i = 0; i < 4; i++) begin
            drive(0, 1, ord[i] / 2 != 0, ord[i] % 2 != 0, tv[ord[i]]);
            tick();
         end
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            $display("FAIL gate_table_%h: got %h expected %h", tv, dut_vec, exp_vec()); n_fail++;
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 1500; n++) begin
         if (m_phase != 1) drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) != 0,
                                 $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
         else              drive($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
                                 $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
         tick();
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            $display("FAIL random_cycle%0d: got %h expected %h", n, dut_vec, exp_vec()); n_fail++;
         end
      end
   endtask

   task automatic test_reset_mid();
      do_start();
      drive(0, 1, 0, 1, 1); tick();
      drive(0, 1, 1, 0, 0); tick();
      n_checks++;
      if (seen !== 4'b0110) begin
         $display("FAIL mid_rows: got seen %b expected 0110", seen); n_fail++;
      end
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (dut_vec !== 15'h0) begin
         $display("FAIL async_reset: got %h expected %h", dut_vec, 15'h0); n_fail++;
      end
      #4;
      rst_n = 1'b1;
      @(posedge clk); #1;
      drive(0, 1, 1, 1, 1);
      tick(); tick();
      n_checks++;
      if (in_ready !== 1'b0 || seen !== 4'b0000 || dut_vec !== exp_vec()) begin
         $display("FAIL idle_after_mid_reset: got %h expected %h", dut_vec, exp_vec()); n_fail++;
      end
      do_start();
      n_checks++;
      if (in_ready !== 1'b1) begin
         $display("FAIL restart_ready: got %b expected 1", in_ready); n_fail++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      model_reset();
      test_reset();
      test_back_to_back();
      test_conflict();
      test_timeout();
      test_start_priority();
      test_duplicate();
      test_all_gates();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
